uart_parity_unit: RTL and testbench
===================================

# uart_parity_unit

Parametrised parity engine for the UART datapath, covering both transmit and receive. On the TX side it computes the parity bit for a parallel word accepted from the host, with runtime-selectable frame length and parity mode (even/odd/mark/space/none). On the RX side it accumulates serially sampled data bits, checks the received parity bit, pulses an error flag and keeps a saturating error count. It sits between the host data interface / TX serializer and the RX sampler.

## Interface
- DATA_W, 8, maximum data bits per frame (legal 5..9)
- ERR_CNT_W, 8, width of the saturating parity-error counter
- CLK  in  1  clock, all logic rising-edge
- RST  in  1  asynchronous, active-low reset
- DATA_VALID  in  1  host word valid
- BUSY  in  1  TX serializer busy; a word is accepted only when DATA_VALID=1 and BUSY=0
- P_DATA  in  DATA_W  parallel TX word, LSB first on the line
- DATA_LEN  in  4  active data bits, 5..DATA_W; values outside that range are clamped to the nearest limit
- PAR_EN  in  1  1 = parity enabled
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- rx_frame_start  in  1  start bit detected; opens a new RX frame
- rx_bit_valid  in  1  strobe: rx_bit is a sampled data bit
- rx_bit  in  1  sampled data bit
- rx_par_valid  in  1  strobe: rx_par_bit is the sampled parity bit
- rx_par_bit  in  1  sampled parity bit
- err_clr  in  1  synchronous clear of err_cnt
- par_bit  out  1  TX parity bit, registered
- par_err  out  1  one-cycle pulse on an RX parity mismatch
- len_err  out  1  one-cycle pulse when a parity strobe arrives before DATA_LEN bits
- err_cnt  out  ERR_CNT_W  saturating count of par_err pulses
- rx_busy  out  1  RX FSM is not in R_IDLE

## Operation
- TX accept (DATA_VALID & ~BUSY):
  - Bits at index DATA_LEN and above are masked to 0.
  - Even mode: par_bit <= ^masked. Odd mode: ~^masked. Mark: 1. Space: 0. PAR_EN=0: par_bit <= 0.
- When no word is accepted, par_bit holds its value. This includes DATA_VALID=1 while BUSY=1.
- RX configuration: DATA_LEN (clamped), PAR_EN and PAR_MODE are latched on rx_frame_start and stay fixed for that frame. Input changes mid-frame have no effect.
- RX FSM:
  - R_IDLE: on rx_frame_start, clear the accumulator and bit count, go to R_DATA.
  - R_DATA: each rx_bit_valid XORs rx_bit into the accumulator and increments the count. When count reaches the latched length: go to R_PAR if PAR_EN, else to R_IDLE with no check. If rx_par_valid arrives while count < length: pulse len_err, no par_err, go to R_IDLE.
  - R_PAR: on rx_par_valid, compute expected parity from the accumulator and the latched mode (same rules as TX). Mismatch pulses par_err. Go to R_IDLE. rx_bit_valid in R_PAR is ignored.
- rx_frame_start in any state aborts the current frame with no error pulse and restarts in R_DATA. This has priority over every other RX event. An rx_bit_valid in the same cycle counts as bit 0 of the new frame.
- err_cnt:
  - Increments on every par_err and saturates at 2^ERR_CNT_W-1.
  - err_clr forces 0. If err_clr coincides with par_err, err_cnt = 1 (the event is not lost).
- Reset values: par_bit=0, par_err=0, len_err=0, err_cnt=0, rx_busy=0, FSM in R_IDLE, accumulator and count 0.

## Timing
- par_bit is valid on the edge after acceptance (latency 1). The serializer samples it no earlier than one cycle after the accept cycle.
- par_err and len_err are registered, asserted exactly one cycle after the rx_par_valid edge, and high for a single cycle.
- err_cnt updates on the same edge that asserts par_err.
- rx_busy rises on the edge after rx_frame_start. It falls on the edge that returns the FSM to R_IDLE.
- Back-to-back frames are supported: rx_frame_start in the cycle immediately after the parity strobe starts a new frame with no gap.
- Reset asserted mid-frame: outputs go to reset values asynchronously. No pulse is emitted on deassertion.

## Test plan
- TX: DATA_LEN=8, even mode, P_DATA=8'hA7 (5 ones) accepted -> par_bit=1 the next cycle. Odd mode, same data -> 0. DATA_VALID with BUSY=1 and new data -> par_bit unchanged.
- TX length mask: DATA_LEN=5, even mode, P_DATA=8'hE1 (low 5 bits 00001) -> par_bit=1. Mark mode -> 1. Space mode -> 0. PAR_EN=0 -> 0.
- RX good/bad: DATA_LEN=8, even mode, bits of 8'h35 (4 ones) then rx_par_bit=0 -> no par_err, err_cnt=0. Repeat with rx_par_bit=1 -> par_err pulses once, err_cnt=1.
- RX abort and short frame: rx_frame_start after 3 bits -> no error, restart, and a 9-strobe frame checks correctly. rx_par_valid after 6 of 8 bits -> len_err pulse, err_cnt unchanged, rx_busy=0 the next cycle.
- Counter: ERR_CNT_W=2, 5 bad frames -> err_cnt stays at 3. err_clr coincident with a par_err -> err_cnt=1.
- Reset mid-frame: RST low after 4 RX bits -> rx_busy=0 and all outputs 0. After release, a full good frame produces no error.

Source files
------------

// File: rtl/uart_parity_unit.sv
// UART parity engine: registered TX parity for host words plus an RX parity checker
// with length checking and a saturating error counter.
module uart_parity_unit #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DATA_VALID,
  input  logic                 BUSY,
  input  logic [DATA_W-1:0]    P_DATA,
  input  logic [3:0]           DATA_LEN,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic                 rx_frame_start,
  input  logic                 rx_bit_valid,
  input  logic                 rx_bit,
  input  logic                 rx_par_valid,
  input  logic                 rx_par_bit,
  input  logic                 err_clr,
  output logic                 par_bit,
  output logic                 par_err,
  output logic                 len_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 rx_busy
);

  localparam logic [3:0] MinLen = 4'd5;
  localparam logic [3:0] MaxLen = 4'(DATA_W);
  localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

  typedef enum logic [1:0] {RIdle, RData, RPar} rx_state_e;

  // Mode 00 even, 01 odd, 10 mark, 11 space; data_xor is the XOR of the active bits.
  function automatic logic parity_of(input logic data_xor, input logic [1:0] mode);
    logic p;
    case (mode)
      2'b00:   p = data_xor;
      2'b01:   p = ~data_xor;
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  logic [3:0] len_clamp;
  logic       tx_xor;
  logic       par_bit_q, par_bit_d;

  rx_state_e      state_q, state_d;
  logic           acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     cfg_len_q, cfg_len_d;
  logic           cfg_en_q, cfg_en_d;
  logic [1:0]     cfg_mode_q, cfg_mode_d;
  logic           par_err_q, par_err_d;
  logic           len_err_q, len_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]     cnt_inc;

  always_comb begin
    len_clamp = DATA_LEN;
    if (DATA_LEN < MinLen) begin
      len_clamp = MinLen;
    end else if (DATA_LEN > MaxLen) begin
      len_clamp = MaxLen;
    end
  end

  always_comb begin
    tx_xor = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (4'(i) < len_clamp) begin
        tx_xor = tx_xor ^ P_DATA[i];
      end
    end
  end

  always_comb begin
    par_bit_d = par_bit_q;
    if (DATA_VALID && !BUSY) begin
      par_bit_d = PAR_EN ? parity_of(tx_xor, PAR_MODE) : 1'b0;
    end
  end

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cfg_len_d  = cfg_len_q;
    cfg_en_d   = cfg_en_q;
    cfg_mode_d = cfg_mode_q;
    par_err_d  = 1'b0;
    len_err_d  = 1'b0;

    // A new start bit overrides everything; a same-cycle data strobe becomes bit 0.
    if (rx_frame_start) begin
      state_d    = RData;
      acc_d      = rx_bit_valid & rx_bit;
      cnt_d      = rx_bit_valid ? 4'd1 : 4'd0;
      cfg_len_d  = len_clamp;
      cfg_en_d   = PAR_EN;
      cfg_mode_d = PAR_MODE;
    end else begin
      case (state_q)
        RData: begin
          if (rx_par_valid) begin
            len_err_d = 1'b1;
            state_d   = RIdle;
          end else if (rx_bit_valid) begin
            acc_d = acc_q ^ rx_bit;
            cnt_d = cnt_inc;
            if (cnt_inc == cfg_len_q) begin
              state_d = cfg_en_q ? RPar : RIdle;
            end
          end
        end
        RPar: begin
          if (rx_par_valid) begin
            par_err_d = (rx_par_bit != parity_of(acc_q, cfg_mode_q));
            state_d   = RIdle;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear wins over the old count but never drops a coincident error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = ERR_CNT_W'(par_err_d);
    end else if (par_err_d && (err_cnt_q != ErrMax)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit_q  <= 1'b0;
      state_q    <= RIdle;
      acc_q      <= 1'b0;
      cnt_q      <= 4'd0;
      cfg_len_q  <= MinLen;
      cfg_en_q   <= 1'b0;
      cfg_mode_q <= 2'b00;
      par_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      par_bit_q  <= par_bit_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      cfg_len_q  <= cfg_len_d;
      cfg_en_q   <= cfg_en_d;
      cfg_mode_q <= cfg_mode_d;
      par_err_q  <= par_err_d;
      len_err_q  <= len_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign par_bit = par_bit_q;
  assign par_err = par_err_q;
  assign len_err = len_err_q;
  assign err_cnt = err_cnt_q;
  assign rx_busy = (state_q != RIdle);

endmodule

// File: tb/tb_uart_parity_unit.sv
// Bench for uart_parity_unit: scoreboard queues hold expected TX parity and RX pulses,
// a second instance with a 2-bit counter exercises saturation.
module tb_uart_parity_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_VALID = 1'b0, BUSY = 1'b0;
  logic [7:0] P_DATA = '0;
  logic [3:0] DATA_LEN = 4'd8;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_MODE = 2'b00;
  logic       rx_frame_start = 1'b0, rx_bit_valid = 1'b0, rx_bit = 1'b0;
  logic       rx_par_valid = 1'b0, rx_par_bit = 1'b0, err_clr = 1'b0;

  logic       par_bit, par_err, len_err, rx_busy;
  logic [7:0] err_cnt;
  logic       par_bit2, par_err2, len_err2, rx_busy2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  int err_m8 = 0;
  int err_m2 = 0;
  logic tx_m = 1'b0;
  logic       tx_q[$];
  logic [1:0] rx_q[$];

  always #5 CLK = ~CLK;

  uart_parity_unit #(.DATA_W(8), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .BUSY(BUSY), .P_DATA(P_DATA),
    .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE),
    .rx_frame_start(rx_frame_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
    .rx_par_valid(rx_par_valid), .rx_par_bit(rx_par_bit), .err_clr(err_clr),
    .par_bit(par_bit), .par_err(par_err), .len_err(len_err), .err_cnt(err_cnt),
    .rx_busy(rx_busy)
  );

  uart_parity_unit #(.DATA_W(8), .ERR_CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .BUSY(BUSY), .P_DATA(P_DATA),
    .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE),
    .rx_frame_start(rx_frame_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
    .rx_par_valid(rx_par_valid), .rx_par_bit(rx_par_bit), .err_clr(err_clr),
    .par_bit(par_bit2), .par_err(par_err2), .len_err(len_err2), .err_cnt(err_cnt2),
    .rx_busy(rx_busy2)
  );

  function automatic int clamp_len(input int len);
    if (len < 5) return 5;
    if (len > 8) return 8;
    return len;
  endfunction

  function automatic logic exp_par(input logic [7:0] d, input int len, input logic [1:0] mode);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(d[i]);
    case (mode)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_err(input logic perr, input logic clr);
    if (clr) begin
      err_m8 = perr ? 1 : 0;
      err_m2 = perr ? 1 : 0;
    end else if (perr) begin
      if (err_m8 < 255) err_m8++;
      if (err_m2 < 3) err_m2++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    step();
    checks++;
    if ({par_bit, par_err, len_err, rx_busy, err_cnt, err_cnt2} !== 14'b0) begin
      errors++;
      $display("FAIL reset: outputs=%b required 0",
               {par_bit, par_err, len_err, rx_busy, err_cnt, err_cnt2});
    end
    RST = 1'b1;
    step();
  endtask

  task automatic tx_word(input logic [7:0] d, input logic [3:0] len, input logic en,
                         input logic [1:0] mode, input logic valid, input logic busy);
    P_DATA = d; DATA_LEN = len; PAR_EN = en; PAR_MODE = mode;
    DATA_VALID = valid; BUSY = busy;
    if (valid && !busy) tx_m = en ? exp_par(d, clamp_len(int'(len)), mode) : 1'b0;
    tx_q.push_back(tx_m);
    step();
    DATA_VALID = 1'b0; BUSY = 1'b0;
    begin
      logic e;
      e = tx_q.pop_front();
      checks++;
      if (par_bit !== e) begin
        errors++;
        $display("FAIL tx_par d=%h len=%0d mode=%b v=%b b=%b: got %b want %b",
                 d, len, mode, valid, busy, par_bit, e);
      end
    end
  endtask

  task automatic test_tx();
    tx_word(8'hA7, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    tx_word(8'hA7, 4'd8, 1'b1, 2'b01, 1'b1, 1'b0);
    tx_word(8'h01, 4'd8, 1'b1, 2'b00, 1'b1, 1'b1);
    tx_word(8'h01, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    tx_word(8'h00, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_tx_mask();
    tx_word(8'hE1, 4'd5, 1'b1, 2'b00, 1'b1, 1'b0);
    tx_word(8'hE1, 4'd5, 1'b1, 2'b11, 1'b1, 1'b0);
    tx_word(8'hE1, 4'd5, 1'b1, 2'b10, 1'b1, 1'b0);
    tx_word(8'hE1, 4'd5, 1'b0, 2'b10, 1'b1, 1'b0);
    tx_word(8'h10, 4'd2, 1'b1, 2'b00, 1'b1, 1'b0);
    tx_word(8'hE0, 4'd5, 1'b1, 2'b00, 1'b1, 1'b0);
  endtask

  // Full RX transaction; ends right after the pulse check so a following call is back-to-back.
  task automatic rx_frame(input logic [7:0] d, input int nbits, input logic [3:0] len,
                          input logic en, input logic [1:0] mode, input logic pbit,
                          input logic clr);
    int   l;
    logic perr, lerr;
    logic [1:0] e;
    l = clamp_len(int'(len));
    DATA_LEN = len; PAR_EN = en; PAR_MODE = mode; rx_frame_start = 1'b1;
    step();
    rx_frame_start = 1'b0;
    // Mid-frame config changes must not affect this frame.
    DATA_LEN = 4'd5; PAR_EN = ~en; PAR_MODE = ~mode;
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rx_busy_rise: got %b want 1", rx_busy);
    end
    for (int i = 0; i < nbits; i++) begin
      rx_bit_valid = 1'b1; rx_bit = d[i];
      step();
    end
    rx_bit_valid = 1'b0;
    if (!en && nbits >= l) begin
      checks++;
      if ({rx_busy, par_err, len_err} !== 3'b000) begin
        errors++;
        $display("FAIL rx_noparity: busy/perr/lerr=%b want 000", {rx_busy, par_err, len_err});
      end
      return;
    end
    lerr = (nbits < l);
    perr = !lerr && (pbit != exp_par(d, l, mode));
    rx_q.push_back({perr, lerr});
    count_err(perr, clr);
    rx_par_valid = 1'b1; rx_par_bit = pbit; err_clr = clr;
    step();
    rx_par_valid = 1'b0; err_clr = 1'b0;
    e = rx_q.pop_front();
    checks++;
    if ({par_err, len_err} !== e || par_err2 !== e[1]) begin
      errors++;
      $display("FAIL rx_pulse d=%h n=%0d mode=%b p=%b: perr/lerr=%b want %b",
               d, nbits, mode, pbit, {par_err, len_err}, e);
    end
    checks++;
    if (err_cnt !== 8'(err_m8) || err_cnt2 !== 2'(err_m2) || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rx_cnt: err_cnt=%0d/%0d busy=%b want %0d/%0d busy=0",
               err_cnt, err_cnt2, rx_busy, err_m8, err_m2);
    end
  endtask

  task automatic check_idle();
    step();
    checks++;
    if ({par_err, len_err, rx_busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle: perr/lerr/busy=%b want 000", {par_err, len_err, rx_busy});
    end
  endtask

  task automatic test_rx_good_bad();
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0);
    check_idle();
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    check_idle();
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b01, 1'b1, 1'b0);
    rx_frame(8'h1F, 5, 4'd3, 1'b1, 2'b00, 1'b1, 1'b0);
    rx_frame(8'h00, 6, 4'd6, 1'b1, 2'b10, 1'b0, 1'b0);
    rx_frame(8'h2B, 6, 4'd6, 1'b0, 2'b00, 1'b0, 1'b0);
    check_idle();
  endtask

  task automatic test_abort_short();
    logic [7:0] d;
    d = 8'h01;
    DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_MODE = 2'b00; rx_frame_start = 1'b1;
    step();
    rx_frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    rx_frame_start = 1'b1; rx_bit_valid = 1'b1; rx_bit = d[0];
    step();
    rx_frame_start = 1'b0;
    checks++;
    if ({par_err, len_err, rx_busy} !== 3'b001) begin
      errors++;
      $display("FAIL abort: perr/lerr/busy=%b want 001", {par_err, len_err, rx_busy});
    end
    for (int i = 1; i < 8; i++) begin
      rx_bit = d[i];
      step();
    end
    rx_bit_valid = 1'b0;
    rx_q.push_back(2'b00);
    rx_par_valid = 1'b1; rx_par_bit = exp_par(d, 8, 2'b00);
    step();
    rx_par_valid = 1'b0;
    begin
      logic [1:0] e;
      e = rx_q.pop_front();
      checks++;
      if ({par_err, len_err} !== e || rx_busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_restart: perr/lerr/busy=%b want %b0",
                 {par_err, len_err, rx_busy}, e);
      end
    end
    rx_frame(8'hFF, 6, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    check_idle();
  endtask

  task automatic test_back_to_back();
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0);
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    rx_frame(8'h0F, 7, 4'd7, 1'b1, 2'b01, 1'b0, 1'b0);
    check_idle();
  endtask

  task automatic test_counter();
    for (int k = 0; k < 5; k++) rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b1, 1'b1);
    err_clr = 1'b1;
    count_err(1'b0, 1'b1);
    step();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'(err_m8) || err_cnt2 !== 2'(err_m2)) begin
      errors++;
      $display("FAIL err_clr: err_cnt=%0d/%0d want %0d/%0d", err_cnt, err_cnt2, err_m8, err_m2);
    end
  endtask

  task automatic test_reset_mid();
    tx_word(8'h01, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    rx_frame(8'h35, 8, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0);
    DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_MODE = 2'b00; rx_frame_start = 1'b1;
    step();
    rx_frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    rx_bit_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({par_bit, par_err, len_err, rx_busy, err_cnt, err_cnt2} !== 14'b0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%b required 0",
               {par_bit, par_err, len_err, rx_busy, err_cnt, err_cnt2});
    end
    err_m8 = 0; err_m2 = 0; tx_m = 1'b0;
    step();
    RST = 1'b1;
    check_idle();
    rx_frame(8'hC3, 8, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0);
    check_idle();
  endtask

  initial begin
    test_reset();
    test_tx();
    test_tx_mask();
    test_rx_good_bad();
    test_abort_short();
    test_back_to_back();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
